// File: rtl/crc_job_sequencer.sv
// crc_job_sequencer: runs one CRC job at a time on the CRC slave bus.
// Write data, start, poll status, read result, stop, then respond.
module crc_job_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CRC_WIDTH-1:0]  rsp_crc,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           jobs_done,
  output logic                  cs,
  output logic                  write,
  output logic                  read,
  output logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_START,
    S_POLL_RD,
    S_POLL_WAIT,
    S_RES_RD,
    S_RES_WAIT,
    S_WR_STOP,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_timeout;
  logic [15:0]           w_poll_inc;
  logic [15:0]           r_poll;
  logic                  r_cs;
  logic                  r_write;
  logic                  r_read;
  logic [1:0]            r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [CRC_WIDTH-1:0]  r_crc;
  logic                  r_err;
  logic [15:0]           r_jobs;
  logic                  w_unused;

  // only bit 0 (status) and the low CRC bits (result) are consumed
  assign w_unused   = ^read_data;
  assign w_poll_inc = r_poll + 16'd1;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state decode, including acceptance and poll timeout
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_WR_DATA;
        end
      end
      S_WR_DATA:  w_next = S_WR_START;
      S_WR_START: w_next = S_POLL_RD;
      S_POLL_RD:  w_next = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (read_data[0]) begin
          w_next = S_RES_RD;
        end else if (w_poll_inc == LP_TIMEOUT) begin
          w_timeout = 1'b1;
          w_next    = S_WR_STOP;
        end else begin
          w_next = S_POLL_RD;
        end
      end
      S_RES_RD:   w_next = S_RES_WAIT;
      S_RES_WAIT: w_next = S_WR_STOP;
      S_WR_STOP:  w_next = S_RESP;
      S_RESP:     if (rsp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // poll counter: cleared on start, bumped on each not-done status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll <= '0;
    end else if (r_state == S_WR_START) begin
      r_poll <= '0;
    end else if (r_state == S_POLL_WAIT && !read_data[0]) begin
      r_poll <= w_poll_inc;
    end
  end

  // bus strobes registered from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs    <= 1'b0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_cs    <= 1'b0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      unique case (1'b1)
        (w_next == S_WR_DATA): begin
          r_cs    <= 1'b1;
          r_write <= 1'b1;
          r_addr  <= 2'd0;
          r_wdata <= req_data;
        end
        (w_next == S_WR_START): begin
          r_cs    <= 1'b1;
          r_write <= 1'b1;
          r_addr  <= 2'd1;
          r_wdata <= DATA_WIDTH'(1);
        end
        (w_next == S_POLL_RD): begin
          r_cs   <= 1'b1;
          r_read <= 1'b1;
          r_addr <= 2'd2;
        end
        (w_next == S_RES_RD): begin
          r_cs   <= 1'b1;
          r_read <= 1'b1;
          r_addr <= 2'd1;
        end
        (w_next == S_WR_STOP): begin
          r_cs    <= 1'b1;
          r_write <= 1'b1;
          r_addr  <= 2'd1;
          r_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // response fields and completed-job counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_crc       <= '0;
      r_err       <= 1'b0;
      r_jobs      <= '0;
    end else begin
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) r_err <= 1'b0;
      if (w_timeout) begin
        r_err <= 1'b1;
        r_crc <= '0;
      end else if (r_state == S_RES_WAIT) begin
        r_crc <= read_data[CRC_WIDTH-1:0];
      end
      if (r_state == S_RESP && rsp_ready) r_jobs <= r_jobs + 16'd1;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_crc    = r_crc;
  assign rsp_err    = r_err;
  assign jobs_done  = r_jobs;
  assign cs         = r_cs;
  assign write      = r_write;
  assign read       = r_read;
  assign addr       = r_addr;
  assign write_data = r_wdata;

endmodule

// File: tb/tb_crc_job_sequencer.sv
// tb_crc_job_sequencer: directed jobs against a CRC slave model,
// with a transaction-level model checked every cycle.
module tb_crc_job_sequencer;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int T  = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] rsp_crc;
  logic          rsp_err;
  logic          busy;
  logic [15:0]   jobs_done;
  logic          cs;
  logic          write;
  logic          read;
  logic [1:0]    addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data = '0;

  crc_job_sequencer #(
    .DATA_WIDTH(DW),
    .CRC_WIDTH (CW),
    .TIMEOUT   (T)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_crc   (rsp_crc),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .jobs_done (jobs_done),
    .cs        (cs),
    .write     (write),
    .read      (read),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         dp;
    logic [2:0] res;
  } cfg_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
  } acc_t;

  typedef struct packed {
    logic [2:0] crc;
    logic       err;
  } rsp_t;

  cfg_t slv_cfg[$];
  cfg_t mdl_cfg[$];
  cfg_t s_cur = '{dp: 0, res: 3'd0};
  int   s_polls = 0;
  logic s_done;

  // slave: status done from poll dp onward (dp=0 never); upper bits junk
  always @(posedge clk) begin
    if (cs && write && addr == 2'd0 && slv_cfg.size() > 0)
      s_cur = slv_cfg.pop_front();
    if (cs && write && addr == 2'd1 && write_data[0])
      s_polls = 0;
    if (cs && read) begin
      if (addr == 2'd2) begin
        s_polls++;
        s_done = (s_cur.dp != 0) && (s_polls >= s_cur.dp);
        read_data <= {31'h7FFF_FFFF, s_done};
      end else if (addr == 2'd1) begin
        read_data <= 32'hA5A5_A5A0 | 32'(s_cur.res);
      end else begin
        read_data <= 32'h0;
      end
    end
  end

  acc_t exp_bus[$];
  rsp_t exp_rsp[$];
  bit   m_busy = 0;
  int   m_jobs = 0;
  bit   m_wait = 0;
  bit   m_lat_ok = 0;
  int   m_acc_edge = 0;
  int   m_lat = 0;
  int   acc_edges[$];
  int   n_r2 = 0;
  int   n_r1 = 0;
  int   last_lat = 0;
  acc_t last_acc = '0;
  logic [31:0] last_w0 = '0;

  // model and per-cycle compare, sampled mid-cycle
  always @(negedge clk) begin
    bit   b0;
    acc_t got;
    acc_t e;
    cfg_t c;
    bit   done;
    int   n;
    if (reset_n) begin
      b0 = m_busy;
      chk("req_ready", 64'(req_ready), 64'(!b0));
      chk("busy", 64'(busy), 64'(b0));
      chk("jobs_done", 64'(jobs_done), 64'(m_jobs[15:0]));
      if (cs) begin
        got = {write, addr, write ? write_data : 32'h0};
        chk("one strobe", 64'(write ^ read), 64'd1);
        if (exp_bus.size() == 0) begin
          chk("unexpected bus access cs", 64'(cs), 64'd0);
        end else begin
          e = exp_bus.pop_front();
          chk("bus access", 64'(got), 64'(e));
        end
        if (read && addr == 2'd2) n_r2++;
        if (read && addr == 2'd1) n_r1++;
        if (write && addr == 2'd0) last_w0 = write_data;
        last_acc = got;
      end else begin
        chk("strobes idle", 64'({write, read}), 64'd0);
      end
      if (rsp_valid) begin
        chk("no bus in RESP", 64'(cs), 64'd0);
        if (exp_rsp.size() == 0) begin
          chk("unexpected rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          if (m_wait) begin
            last_lat = cyc + 1 - m_acc_edge;
            if (m_lat_ok) chk("latency", 64'(last_lat), 64'(m_lat));
            m_wait = 0;
          end
          chk("rsp fields", 64'({rsp_crc, rsp_err}), 64'(exp_rsp[0]));
          if (rsp_ready) begin
            void'(exp_rsp.pop_front());
            m_jobs++;
            m_busy = 0;
          end
        end
      end else if (b0 && !m_wait) begin
        chk("rsp_valid held", 64'(rsp_valid), 64'd1);
      end
      if (req_valid && !b0) begin
        if (mdl_cfg.size() == 0) begin
          chk("job accepted without config", 64'(req_valid), 64'd0);
        end else begin
          c = mdl_cfg.pop_front();
          done = (c.dp >= 1) && (c.dp <= T);
          n = done ? c.dp : T;
          exp_bus.push_back({1'b1, 2'd0, req_data});
          exp_bus.push_back({1'b1, 2'd1, 32'd1});
          for (int i = 0; i < n; i++) exp_bus.push_back({1'b0, 2'd2, 32'd0});
          if (done) exp_bus.push_back({1'b0, 2'd1, 32'd0});
          exp_bus.push_back({1'b1, 2'd1, 32'd0});
          exp_rsp.push_back(done ? rsp_t'({c.res, 1'b0}) : rsp_t'(4'b0001));
          m_busy = 1;
          m_wait = 1;
          m_acc_edge = cyc + 1;
          m_lat = 2 + 2 * n + (done ? 2 : 0) + 2;
          m_lat_ok = done;
          acc_edges.push_back(cyc + 1);
          n_r2 = 0;
          n_r1 = 0;
        end
      end
    end
  end

  task automatic push_cfg(input int dp, input logic [2:0] res);
    slv_cfg.push_back('{dp: dp, res: res});
    mdl_cfg.push_back('{dp: dp, res: res});
  endtask

  task automatic wait_accept(input string nm);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      k++;
      if (k > 100) begin
        chk({nm, " accept timeout"}, 64'(req_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic run_job(input logic [31:0] d, input int dp,
                         input logic [2:0] res, input int stall);
    int k;
    push_cfg(dp, res);
    @(posedge clk);
    #1;
    req_data  = d;
    req_valid = 1'b1;
    wait_accept("job");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      k++;
      if (k > 200) begin
        chk("rsp_valid timeout", 64'(rsp_valid), 64'd1);
        break;
      end
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        req_valid = 1'b1;
        req_data  = 32'h1111_1111;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      chk("stall rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall req_ready", 64'(req_ready), 64'd0);
      chk("stall cs", 64'(cs), 64'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset jobs_done", 64'(jobs_done), 64'd0);
    chk("reset cs", 64'(cs), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    run_job(32'hDEAD_BEEF, 1, 3'b101, 0);
    chk("t1 crc", 64'(rsp_crc), 64'd5);
    chk("t1 err", 64'(rsp_err), 64'd0);
    chk("t1 jobs_done", 64'(jobs_done), 64'd1);
    chk("t1 latency", 64'(last_lat), 64'd8);
    chk("t1 polls", 64'(n_r2), 64'd1);
    chk("t1 result reads", 64'(n_r1), 64'd1);
    chk("t1 data write", 64'(last_w0), 64'hDEAD_BEEF);
    chk("t1 req_ready", 64'(req_ready), 64'd1);

    run_job(32'h1234_5678, 4, 3'b011, 0);
    chk("t2 polls", 64'(n_r2), 64'd4);
    chk("t2 latency", 64'(last_lat), 64'd14);
    chk("t2 crc", 64'(rsp_crc), 64'd3);
    chk("t2 err", 64'(rsp_err), 64'd0);

    run_job(32'hCAFE_F00D, 0, 3'b111, 0);
    chk("t3 polls", 64'(n_r2), 64'd5);
    chk("t3 result reads", 64'(n_r1), 64'd0);
    chk("t3 stop write", 64'(last_acc), 64'({1'b1, 2'b01, 32'h0}));
    chk("t3 err", 64'(rsp_err), 64'd1);
    chk("t3 crc", 64'(rsp_crc), 64'd0);
    chk("t3 jobs_done", 64'(jobs_done), 64'd3);

    run_job(32'h0BAD_F00D, 2, 3'b110, 10);
    chk("t4 jobs_done", 64'(jobs_done), 64'd4);
    chk("t4 crc", 64'(rsp_crc), 64'd6);
    chk("t4 err cleared", 64'(rsp_err), 64'd0);
    chk("t4 req_ready", 64'(req_ready), 64'd1);
    repeat (6) @(negedge clk);

    push_cfg(0, 3'b000);
    @(posedge clk);
    #1;
    req_data  = 32'h55AA_55AA;
    req_valid = 1'b1;
    wait_accept("reset job");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (cs && read && addr == 2'd2) break;
      k++;
      if (k > 50) begin
        chk("reset job poll timeout", 64'(cs), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst cs", 64'(cs), 64'd0);
    chk("arst write", 64'(write), 64'd0);
    chk("arst read", 64'(read), 64'd0);
    chk("arst addr", 64'(addr), 64'd0);
    chk("arst write_data", 64'(write_data), 64'd0);
    chk("arst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst rsp_crc", 64'(rsp_crc), 64'd0);
    chk("arst rsp_err", 64'(rsp_err), 64'd0);
    chk("arst jobs_done", 64'(jobs_done), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst req_ready", 64'(req_ready), 64'd1);
    exp_bus.delete();
    exp_rsp.delete();
    m_busy = 0;
    m_jobs = 0;
    m_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post-reset req_ready", 64'(req_ready), 64'd1);
    chk("post-reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post-reset jobs_done", 64'(jobs_done), 64'd0);

    acc_edges.delete();
    push_cfg(1, 3'b001);
    push_cfg(1, 3'b010);
    push_cfg(1, 3'b011);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = 32'h100 + 32'(i);
      wait_accept("b2b");
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    k = 0;
    while (m_jobs < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("b2b jobs_done", 64'(jobs_done), 64'd3);
    chk("b2b accepts", 64'(acc_edges.size()), 64'd3);
    if (acc_edges.size() == 3) begin
      chk("b2b spacing 1", 64'(acc_edges[1] - acc_edges[0]), 64'd9);
      chk("b2b spacing 2", 64'(acc_edges[2] - acc_edges[1]), 64'd9);
    end
    chk("b2b last crc", 64'(rsp_crc), 64'd3);
    repeat (4) @(negedge clk);
    chk("trace drained", 64'(exp_bus.size()), 64'd0);
    chk("responses drained", 64'(exp_rsp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
